// File: rtl/serial_unloader_if.sv
// Load-side handshake between a word producer and the serial unloader.
// The producer drives the word and its valid flag; the unloader answers with ready.
interface serial_unloader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             ld_valid;
    logic             ld_ready;

    modport master (output D, output ld_valid, input ld_ready);
    modport slave  (input D, input ld_valid, output ld_ready);
endinterface

// File: rtl/serial_unloader.sv
// Parallel-to-serial frame unloader: start bit, LSB-first data, optional even parity, stop bit.
// The line advances one bit per tick strobe and holds its value while tick is low.
module serial_unloader #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                r,
    serial_unloader_if.slave    ld,
    input  logic                tick,
    output logic                sout,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    bit_count, count_next;
    logic             parity, parity_next;
    logic             done_next;

    // State and datapath registers; reset leaves the line idle and ready for a word.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_count <= '0;
            parity    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_count <= count_next;
            parity    <= parity_next;
            done      <= done_next;
        end
    end

    // Next-state logic. The acceptance cycle ignores tick, so START always waits
    // for the first strobe after the word was taken.
    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        count_next  = bit_count;
        parity_next = parity;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (ld.ld_valid) begin
                    state_next  = START;
                    shift_next  = ld.D;
                    parity_next = ^ld.D;
                    count_next  = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    count_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    count_next = bit_count + 1'b1;
                    if (bit_count == CW'(WIDTH - 1)) begin
                        state_next = PARITY_EN ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line value is a pure decode of registered state, so D and ld_valid never reach it.
    always_comb begin
        case (state)
            START:   sout = 1'b0;
            DATA:    sout = shift_reg[0];
            PAR:     sout = parity;
            default: sout = 1'b1;
        endcase
    end

    assign ld.ld_ready = (state == IDLE);
    assign busy        = (state != IDLE);

endmodule
